// File: rtl/mips_fetch_pkg.sv
// Shared types and helpers for the MIPS instruction-fetch sequencer.
package mips_fetch_pkg;

    localparam int INSTR_W      = 32;
    localparam int ADDR_W       = 32;
    localparam int ROM_WIN_BITS = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // True when the upper address bits select the 128-byte ROM window.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-ROM_WIN_BITS-1:0] base);
        return addr[ADDR_W-1:ROM_WIN_BITS] == base;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of {pc, instr} between the ROM fetch stage and decode.
module fetch_skid_buf
    import mips_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  wr_pc,
    input  logic [INSTR_W-1:0] wr_instr,
    output logic               full,
    output logic               empty,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    localparam int ENTRY_W = ADDR_W + INSTR_W;

    // slot0 is always the head; slot1 only holds data when two entries are live.
    logic [ENTRY_W-1:0] slot0_q, slot0_d;
    logic [ENTRY_W-1:0] slot1_q, slot1_d;
    logic [1:0]         count_q, count_d;
    logic [ENTRY_W-1:0] wr_entry;

    assign wr_entry = {wr_pc, wr_instr};

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) slot0_d = wr_entry;
                    else                 slot1_d = wr_entry;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        slot0_d = slot1_q;
                        slot1_d = wr_entry;
                    end else begin
                        slot0_d = wr_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign empty      = (count_q == 2'd0);
    assign full       = (count_q == 2'd2);
    assign head_pc    = empty ? '0 : slot0_q[ENTRY_W-1:INSTR_W];
    assign head_instr = empty ? '0 : slot0_q[INSTR_W-1:0];

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, ROM addressing, redirects and fault detection.
// Optional FETCH_PERF_EN adds push/stall counters and a push trace.
module rom_fetch_ctrl
    import mips_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0]              RESET_PC  = 32'h0000_0000,
    parameter logic [ADDR_W-ROM_WIN_BITS-1:0] ROM_BASE  = 25'd0,
    parameter int                             BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               fetch_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stalls
`endif
);

    if (BUF_DEPTH != 2) begin : g_bad_depth
        $error("rom_fetch_ctrl supports BUF_DEPTH=2 only");
    end

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              push, pop, flush, buf_full, buf_empty;

    assign pop = if_valid && if_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (redirect_valid) begin
            flush = 1'b1;
            pc_d  = redirect_pc;
            if (redirect_pc[1:0] != 2'b00 || !in_window(redirect_pc, ROM_BASE))
                state_d = ST_FAULT;
            else
                state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN: begin
                    if (!in_window(pc_q, ROM_BASE)) begin
                        state_d = ST_FAULT;
                    end else if (!buf_full || pop) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end
                ST_FAULT: ;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_skid_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .wr_pc      (pc_q),
        .wr_instr   (rom_data),
        .full       (buf_full),
        .empty      (buf_empty),
        .head_pc    (if_pc),
        .head_instr (if_instr)
    );

    assign rom_addr  = pc_q;
    assign if_valid  = !buf_empty;
    assign fetch_err = (state_q == ST_FAULT);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + {31'd0, push};
        perf_stalls_d  = perf_stalls_q
                       + {31'd0, (state_q == ST_RUN) && buf_full && !pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stalls_q  <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stalls_q  <= perf_stalls_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stalls  = perf_stalls_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && push)
            $display("%0t fetch push pc=%h instr=%h", $time, pc_q, rom_data);
    end
`endif
`endif

endmodule
